// File: rtl/fl_alloc_ctrl_pkg.sv
// Shared defaults and helpers for the rename-stage free-list allocation controller.
package fl_alloc_ctrl_pkg;

    localparam int unsigned N_DEF        = 3;
    localparam int unsigned ROB_SZ_DEF   = 32;
    localparam int unsigned BR_SLOTS_DEF = 4;

    // Index width that stays legal when the indexed set has a single entry.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fl_alloc_ctrl_ckpt_alloc.sv
// Priority selector: returns up to N lowest-index free branch checkpoints, lowest first.
module br_ckpt_alloc
    import fl_alloc_ctrl_pkg::*;
#(
    parameter  int unsigned N        = N_DEF,
    parameter  int unsigned BR_SLOTS = BR_SLOTS_DEF,
    localparam int unsigned TW       = idx_w(BR_SLOTS),
    localparam int unsigned IW       = idx_w(N)
) (
    input  logic [BR_SLOTS-1:0]      free_mask,
    output logic [N-1:0][TW-1:0]     sel_tag
);

    int unsigned k;

    always_comb begin
        sel_tag = '0;
        k       = 0;
        for (int unsigned j = 0; j < BR_SLOTS; j++) begin
            if (free_mask[j] && (k < N)) begin
                sel_tag[IW'(k)] = TW'(j);
                k = k + 1;
            end
        end
    end

endmodule

// File: rtl/fl_alloc_ctrl.sv
// Rename-stage controller: in-order dispatch grants bounded by free registers and
// branch checkpoints, plus a checkpoint table of free-list state for early branch recovery.
module fl_alloc_ctrl
    import fl_alloc_ctrl_pkg::*;
#(
    parameter  int unsigned N        = N_DEF,
    parameter  int unsigned DEPTH    = ROB_SZ_DEF,
    parameter  int unsigned BR_SLOTS = BR_SLOTS_DEF,
    localparam int unsigned GW       = $clog2(N + 1),
    localparam int unsigned TW       = idx_w(BR_SLOTS),
    localparam int unsigned IW       = idx_w(N),
    localparam int unsigned PW       = $clog2(DEPTH),
    localparam int unsigned CW       = $clog2(DEPTH + 1),
    localparam int unsigned BW       = $clog2(BR_SLOTS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          disp_valid,
    input  logic [N-1:0]          disp_needs_reg,
    input  logic [N-1:0]          disp_is_branch,
    input  logic [GW-1:0]         retire_free_num,
    input  logic [PW-1:0]         fl_head,
    input  logic                  br_resolve,
    input  logic [TW-1:0]         br_resolve_tag,
    input  logic                  br_mispredict,
    output logic [GW-1:0]         disp_grant_num,
    output logic [N-1:0][TW-1:0]  br_tag_out,
    output logic [GW-1:0]         rd_num,
    output logic [GW-1:0]         wr_num,
    output logic                  br_en,
    output logic [CW-1:0]         head_ptr_in,
    output logic [CW-1:0]         free_count
);

    typedef struct packed {
        logic                valid;
        logic [PW-1:0]       head;
        logic [CW-1:0]       cnt;
        logic [BR_SLOTS-1:0] dep_mask;
    } br_ckpt_packet_t;

    br_ckpt_packet_t [BR_SLOTS-1:0] ckpt;
    br_ckpt_packet_t [BR_SLOTS-1:0] ckpt_next;
    logic [CW-1:0]                  free_count_next;

    logic [BR_SLOTS-1:0]            valid_vec;
    logic [BW-1:0]                  free_ckpts;
    logic [N-1:0][TW-1:0]           sel_tag;
    logic                           resolve_hit;
    logic                           misp_hit;

    logic [CW-1:0]                  n_reg;
    logic [CW-1:0]                  n_reg_try;
    logic [BW:0]                    n_br;
    logic [BW:0]                    n_br_try;
    logic                           stop;
    logic [TW-1:0]                  cur_tag;

    logic [BR_SLOTS-1:0]            alloc_en;
    logic [BR_SLOTS-1:0][PW-1:0]    alloc_head;
    logic [BR_SLOTS-1:0][CW-1:0]    alloc_cnt;
    logic [BR_SLOTS-1:0][BR_SLOTS-1:0] alloc_dep;
    logic [BR_SLOTS-1:0]            drop;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [GW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + (CW+1)'(b);
        return (s > (CW+1)'(DEPTH)) ? CW'(DEPTH) : CW'(s);
    endfunction

    always_comb begin
        valid_vec  = '0;
        free_ckpts = '0;
        for (int unsigned j = 0; j < BR_SLOTS; j++) begin
            valid_vec[j] = ckpt[j].valid;
            free_ckpts   = free_ckpts + BW'(!ckpt[j].valid);
        end
    end

    assign resolve_hit = br_resolve & ckpt[br_resolve_tag].valid;
    assign misp_hit    = resolve_hit & br_mispredict;

    br_ckpt_alloc #(
        .N        (N),
        .BR_SLOTS (BR_SLOTS)
    ) u_ckpt_alloc (
        .free_mask (~valid_vec),
        .sel_tag   (sel_tag)
    );

    // In-order grant; each granted branch snapshots the free list as it stands after its own slot.
    always_comb begin
        disp_grant_num = '0;
        br_tag_out     = '0;
        alloc_en       = '0;
        alloc_head     = '0;
        alloc_cnt      = '0;
        alloc_dep      = '0;
        n_reg          = '0;
        n_br           = '0;
        n_reg_try      = '0;
        n_br_try       = '0;
        cur_tag        = '0;
        stop           = reset | misp_hit;
        for (int unsigned i = 0; i < N; i++) begin
            n_reg_try = n_reg + CW'(disp_needs_reg[i]);
            n_br_try  = n_br + (BW+1)'(disp_is_branch[i]);
            if (!stop && disp_valid[i] && (n_reg_try <= free_count)
                && (n_br_try <= {1'b0, free_ckpts})) begin
                n_reg          = n_reg_try;
                n_br           = n_br_try;
                disp_grant_num = GW'(i + 1);
                if (disp_is_branch[i]) begin
                    cur_tag              = sel_tag[IW'(n_br - 1'b1)];
                    br_tag_out[i]        = cur_tag;
                    alloc_dep[cur_tag]   = valid_vec | alloc_en;
                    alloc_en[cur_tag]    = 1'b1;
                    alloc_head[cur_tag]  = fl_head + PW'(n_reg);
                    alloc_cnt[cur_tag]   = free_count - n_reg;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        rd_num      = GW'(n_reg);
        wr_num      = retire_free_num;
        br_en       = !reset && misp_hit;
        head_ptr_in = br_en ? CW'(ckpt[br_resolve_tag].head) : '0;
    end

    always_comb begin
        ckpt_next = ckpt;
        drop      = '0;
        for (int unsigned j = 0; j < BR_SLOTS; j++) begin
            if (alloc_en[j]) begin
                ckpt_next[j].valid    = 1'b1;
                ckpt_next[j].head     = alloc_head[j];
                ckpt_next[j].cnt      = alloc_cnt[j];
                ckpt_next[j].dep_mask = alloc_dep[j];
            end
            if (ckpt_next[j].valid) begin
                ckpt_next[j].cnt = sat_add(ckpt_next[j].cnt, retire_free_num);
            end
        end
        // A correct resolve drops only T; a mispredict also drops everything younger than T.
        if (resolve_hit) begin
            drop[br_resolve_tag] = 1'b1;
            if (br_mispredict) begin
                for (int unsigned j = 0; j < BR_SLOTS; j++) begin
                    if (ckpt[j].dep_mask[br_resolve_tag]) drop[j] = 1'b1;
                end
            end
        end
        for (int unsigned j = 0; j < BR_SLOTS; j++) begin
            if (drop[j]) ckpt_next[j].valid = 1'b0;
            ckpt_next[j].dep_mask = ckpt_next[j].dep_mask & ~drop;
        end
        if (misp_hit) free_count_next = sat_add(ckpt[br_resolve_tag].cnt, retire_free_num);
        else          free_count_next = sat_add(free_count - CW'(rd_num), retire_free_num);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_count <= CW'(DEPTH);
            ckpt       <= '0;
        end else begin
            free_count <= free_count_next;
            ckpt       <= ckpt_next;
        end
    end

endmodule

// File: tb/tb_fl_alloc_ctrl.sv
// Self-checking bench for fl_alloc_ctrl: directed scenarios plus randomized traffic
// compared against a queue/sequence-number reference model of the checkpoint table.
module tb_fl_alloc_ctrl;

    localparam int unsigned N        = 3;
    localparam int unsigned DEPTH    = 32;
    localparam int unsigned BR_SLOTS = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [2:0]       disp_valid;
    logic [2:0]       disp_needs_reg;
    logic [2:0]       disp_is_branch;
    logic [1:0]       retire_free_num;
    logic [4:0]       fl_head;
    logic             br_resolve;
    logic [1:0]       br_resolve_tag;
    logic             br_mispredict;
    logic [1:0]       disp_grant_num;
    logic [2:0][1:0]  br_tag_out;
    logic [1:0]       rd_num;
    logic [1:0]       wr_num;
    logic             br_en;
    logic [5:0]       head_ptr_in;
    logic [5:0]       free_count;

    int passed = 0;
    int total  = 0;

    // Reference model: free count plus checkpoints ordered by allocation sequence number.
    int m_fc;
    bit m_v[BR_SLOTS];
    int m_head[BR_SLOTS];
    int m_cnt[BR_SLOTS];
    int m_seq[BR_SLOTS];
    int seq_ctr;
    int e_grant, e_rd, e_head;
    bit e_br_en;
    int e_tag[N];
    int a_n;
    int a_tag[N], a_head[N], a_cnt[N];

    fl_alloc_ctrl #(
        .N        (N),
        .DEPTH    (DEPTH),
        .BR_SLOTS (BR_SLOTS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .disp_valid      (disp_valid),
        .disp_needs_reg  (disp_needs_reg),
        .disp_is_branch  (disp_is_branch),
        .retire_free_num (retire_free_num),
        .fl_head         (fl_head),
        .br_resolve      (br_resolve),
        .br_resolve_tag  (br_resolve_tag),
        .br_mispredict   (br_mispredict),
        .disp_grant_num  (disp_grant_num),
        .br_tag_out      (br_tag_out),
        .rd_num          (rd_num),
        .wr_num          (wr_num),
        .br_en           (br_en),
        .head_ptr_in     (head_ptr_in),
        .free_count      (free_count)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        disp_valid      = '0;
        disp_needs_reg  = '0;
        disp_is_branch  = '0;
        retire_free_num = '0;
        fl_head         = '0;
        br_resolve      = 1'b0;
        br_resolve_tag  = '0;
        br_mispredict   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_fc    = DEPTH;
        seq_ctr = 0;
        for (int t = 0; t < BR_SLOTS; t++) begin
            m_v[t] = 1'b0; m_head[t] = 0; m_cnt[t] = 0; m_seq[t] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic model_eval();
        int free_list[$];
        int regs, brs, rt;
        free_list = {};
        for (int t = 0; t < BR_SLOTS; t++) if (!m_v[t]) free_list.push_back(t);
        rt      = int'(br_resolve_tag);
        e_br_en = br_resolve && br_mispredict && m_v[rt];
        e_head  = e_br_en ? m_head[rt] : 0;
        e_grant = 0;
        a_n     = 0;
        regs    = 0;
        brs     = 0;
        for (int i = 0; i < N; i++) e_tag[i] = 0;
        if (!e_br_en) begin
            for (int i = 0; i < N; i++) begin
                if (!disp_valid[i]) break;
                if (regs + int'(disp_needs_reg[i]) > m_fc) break;
                if (brs + int'(disp_is_branch[i]) > free_list.size()) break;
                regs += int'(disp_needs_reg[i]);
                brs  += int'(disp_is_branch[i]);
                e_grant = i + 1;
                if (disp_is_branch[i]) begin
                    e_tag[i]    = free_list[brs-1];
                    a_tag[a_n]  = e_tag[i];
                    a_head[a_n] = (int'(fl_head) + regs) % DEPTH;
                    a_cnt[a_n]  = m_fc - regs;
                    a_n++;
                end
            end
        end
        e_rd = regs;
    endtask

    task automatic model_commit();
        int rt, ret, nfc, s;
        bit hit;
        rt  = int'(br_resolve_tag);
        ret = int'(retire_free_num);
        hit = br_resolve && m_v[rt];
        nfc = e_br_en ? m_cnt[rt] + ret : m_fc - e_rd + ret;
        m_fc = (nfc > DEPTH) ? DEPTH : nfc;
        for (int k = 0; k < a_n; k++) begin
            m_v[a_tag[k]]    = 1'b1;
            m_head[a_tag[k]] = a_head[k];
            m_cnt[a_tag[k]]  = a_cnt[k];
            m_seq[a_tag[k]]  = seq_ctr++;
        end
        for (int t = 0; t < BR_SLOTS; t++)
            if (m_v[t]) m_cnt[t] = (m_cnt[t] + ret > DEPTH) ? DEPTH : m_cnt[t] + ret;
        if (hit) begin
            if (br_mispredict) begin
                s = m_seq[rt];
                for (int t = 0; t < BR_SLOTS; t++) if (m_v[t] && m_seq[t] > s) m_v[t] = 1'b0;
            end
            m_v[rt] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        disp_valid = 3'b111; disp_needs_reg = 3'b111; disp_is_branch = 3'b111;
        br_resolve = 1'b1; br_mispredict = 1'b1;
        tick();
        total++; if (disp_grant_num !== 2'd0) $display("FAIL reset_grant: got %0d expected 0", disp_grant_num); else passed++;
        total++; if (rd_num !== 2'd0) $display("FAIL reset_rd: got %0d expected 0", rd_num); else passed++;
        total++; if (br_en !== 1'b0) $display("FAIL reset_br_en: got %0d expected 0", br_en); else passed++;
        total++; if (head_ptr_in !== 6'd0) $display("FAIL reset_head: got %0d expected 0", head_ptr_in); else passed++;
        total++; if (br_tag_out !== 6'd0) $display("FAIL reset_tags: got %h expected 0", br_tag_out); else passed++;
        total++; if (free_count !== 6'd32) $display("FAIL reset_free_count: got %0d expected 32", free_count); else passed++;
        reset = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    task automatic test_basic_grant();
        do_reset();
        disp_valid = 3'b111; disp_needs_reg = 3'b111;
        #1;
        total++; if (disp_grant_num !== 2'd3) $display("FAIL basic_grant: got %0d expected 3", disp_grant_num); else passed++;
        total++; if (rd_num !== 2'd3) $display("FAIL basic_rd: got %0d expected 3", rd_num); else passed++;
        tick();
        idle_inputs();
        #1;
        total++; if (free_count !== 6'd29) $display("FAIL basic_free_count: got %0d expected 29", free_count); else passed++;
    endtask

    task automatic test_reg_limit();
        disp_valid = 3'b111; disp_needs_reg = 3'b111;
        for (int c = 0; c < 9; c++) tick();
        idle_inputs();
        #1;
        total++; if (free_count !== 6'd2) $display("FAIL drain_free_count: got %0d expected 2", free_count); else passed++;
        disp_valid = 3'b111; disp_needs_reg = 3'b111; retire_free_num = 2'd3;
        #1;
        total++; if (disp_grant_num !== 2'd2) $display("FAIL reg_limit_grant: got %0d expected 2", disp_grant_num); else passed++;
        total++; if (rd_num !== 2'd2) $display("FAIL reg_limit_rd: got %0d expected 2", rd_num); else passed++;
        total++; if (wr_num !== 2'd3) $display("FAIL reg_limit_wr: got %0d expected 3", wr_num); else passed++;
        tick();
        idle_inputs();
        #1;
        total++; if (free_count !== 6'd3) $display("FAIL reg_limit_free_count: got %0d expected 3", free_count); else passed++;
    endtask

    task automatic test_branch_limit();
        do_reset();
        disp_valid = 3'b111; disp_is_branch = 3'b111;
        #1;
        total++; if (disp_grant_num !== 2'd3) $display("FAIL br_limit_grant1: got %0d expected 3", disp_grant_num); else passed++;
        total++; if (br_tag_out !== {2'd2, 2'd1, 2'd0}) $display("FAIL br_limit_tags1: got %h expected 24", br_tag_out); else passed++;
        tick();
        #1;
        total++; if (disp_grant_num !== 2'd1) $display("FAIL br_limit_grant2: got %0d expected 1", disp_grant_num); else passed++;
        total++; if (br_tag_out !== {2'd0, 2'd0, 2'd3}) $display("FAIL br_limit_tags2: got %h expected 03", br_tag_out); else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_mispredict_head();
        do_reset();
        fl_head = 5'd5; disp_valid = 3'b011; disp_needs_reg = 3'b011; disp_is_branch = 3'b010;
        #1;
        total++; if (disp_grant_num !== 2'd2) $display("FAIL ckpt_grant: got %0d expected 2", disp_grant_num); else passed++;
        total++; if (rd_num !== 2'd2) $display("FAIL ckpt_rd: got %0d expected 2", rd_num); else passed++;
        tick();
        idle_inputs();
        fl_head = 5'd7; disp_valid = 3'b111; disp_needs_reg = 3'b111; retire_free_num = 2'd1;
        #1;
        total++; if (disp_grant_num !== 2'd3) $display("FAIL ckpt_mid_grant: got %0d expected 3", disp_grant_num); else passed++;
        tick();
        idle_inputs();
        #1;
        total++; if (free_count !== 6'd28) $display("FAIL ckpt_mid_free_count: got %0d expected 28", free_count); else passed++;
        disp_valid = 3'b111; disp_needs_reg = 3'b111;
        br_resolve = 1'b1; br_resolve_tag = 2'd0; br_mispredict = 1'b1;
        #1;
        total++; if (disp_grant_num !== 2'd0) $display("FAIL misp_grant: got %0d expected 0", disp_grant_num); else passed++;
        total++; if (rd_num !== 2'd0) $display("FAIL misp_rd: got %0d expected 0", rd_num); else passed++;
        total++; if (br_en !== 1'b1) $display("FAIL misp_br_en: got %0d expected 1", br_en); else passed++;
        total++; if (head_ptr_in !== 6'd7) $display("FAIL misp_head: got %0d expected 7", head_ptr_in); else passed++;
        tick();
        idle_inputs();
        #1;
        total++; if (free_count !== 6'd31) $display("FAIL misp_free_count: got %0d expected 31", free_count); else passed++;
    endtask

    task automatic test_nested_flush();
        do_reset();
        disp_valid = 3'b011; disp_is_branch = 3'b011;
        #1;
        total++; if (br_tag_out !== {2'd0, 2'd1, 2'd0}) $display("FAIL nest_tags: got %h expected 04", br_tag_out); else passed++;
        tick();
        idle_inputs();
        br_resolve = 1'b1; br_resolve_tag = 2'd0; br_mispredict = 1'b1;
        #1;
        total++; if (br_en !== 1'b1) $display("FAIL nest_br_en: got %0d expected 1", br_en); else passed++;
        tick();
        idle_inputs();
        disp_valid = 3'b111; disp_is_branch = 3'b111;
        #1;
        total++; if (disp_grant_num !== 2'd3) $display("FAIL nest_regrant: got %0d expected 3", disp_grant_num); else passed++;
        tick();
        #1;
        total++; if (br_tag_out !== {2'd0, 2'd0, 2'd3}) $display("FAIL nest_fourth_tag: got %h expected 03", br_tag_out); else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_resolve_then_misp();
        do_reset();
        fl_head = 5'd3; disp_valid = 3'b011; disp_needs_reg = 3'b011; disp_is_branch = 3'b011;
        tick();
        idle_inputs();
        br_resolve = 1'b1; br_resolve_tag = 2'd0;
        #1;
        total++; if (br_en !== 1'b0) $display("FAIL commit_br_en: got %0d expected 0", br_en); else passed++;
        tick();
        idle_inputs();
        disp_valid = 3'b111; disp_needs_reg = 3'b111;
        br_resolve = 1'b1; br_resolve_tag = 2'd1; br_mispredict = 1'b1;
        #1;
        total++; if (disp_grant_num !== 2'd0) $display("FAIL late_misp_grant: got %0d expected 0", disp_grant_num); else passed++;
        total++; if (head_ptr_in !== 6'd5) $display("FAIL late_misp_head: got %0d expected 5", head_ptr_in); else passed++;
        tick();
        idle_inputs();
        disp_valid = 3'b111; disp_is_branch = 3'b111;
        #1;
        total++; if (free_count !== 6'd30) $display("FAIL late_misp_free_count: got %0d expected 30", free_count); else passed++;
        total++; if (br_tag_out !== {2'd2, 2'd1, 2'd0}) $display("FAIL late_misp_tags: got %h expected 24", br_tag_out); else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [2:0][1:0] et;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            disp_valid      = 3'($urandom_range(0, 7));
            disp_needs_reg  = 3'($urandom_range(0, 7));
            disp_is_branch  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            retire_free_num = 2'($urandom_range(0, 3));
            fl_head         = 5'($urandom_range(0, 31));
            br_resolve      = ($urandom_range(0, 2) == 0);
            br_resolve_tag  = 2'($urandom_range(0, 3));
            br_mispredict   = ($urandom_range(0, 3) == 0);
            #1;
            model_eval();
            for (int i = 0; i < N; i++) et[i] = 2'(e_tag[i]);
            total++; if (disp_grant_num !== 2'(e_grant)) $display("FAIL rand_grant c%0d: got %0d expected %0d", c, disp_grant_num, e_grant); else passed++;
            total++; if (rd_num !== 2'(e_rd)) $display("FAIL rand_rd c%0d: got %0d expected %0d", c, rd_num, e_rd); else passed++;
            total++; if (wr_num !== retire_free_num) $display("FAIL rand_wr c%0d: got %0d expected %0d", c, wr_num, retire_free_num); else passed++;
            total++; if (br_en !== e_br_en) $display("FAIL rand_br_en c%0d: got %0d expected %0d", c, br_en, e_br_en); else passed++;
            total++; if (head_ptr_in !== 6'(e_head)) $display("FAIL rand_head c%0d: got %0d expected %0d", c, head_ptr_in, e_head); else passed++;
            total++; if (br_tag_out !== et) $display("FAIL rand_tags c%0d: got %h expected %h", c, br_tag_out, et); else passed++;
            total++; if (free_count !== 6'(m_fc)) $display("FAIL rand_free_count c%0d: got %0d expected %0d", c, free_count, m_fc); else passed++;
            @(posedge clock);
            model_commit();
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_basic_grant();
        test_reg_limit();
        test_branch_limit();
        test_mispredict_head();
        test_nested_flush();
        test_resolve_then_misp();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
